// File: rtl/lcd_pkg.sv
// lcd_pkg: shared RGB888 type, colour-bar palette and default
// 480x272 panel timing for the RGB LCD path.
package lcd_pkg;

    localparam int CNT_W = 11;

    typedef logic [23:0] rgb_t;

    localparam rgb_t WHITE   = 24'hFFFFFF;
    localparam rgb_t YELLOW  = 24'hFFFF00;
    localparam rgb_t CYAN    = 24'h00FFFF;
    localparam rgb_t GREEN   = 24'h00FF00;
    localparam rgb_t MAGENTA = 24'hFF00FF;
    localparam rgb_t RED     = 24'hFF0000;
    localparam rgb_t BLUE    = 24'h0000FF;
    localparam rgb_t BLACK   = 24'h000000;

    localparam int H_SYNC_DEF  = 41;
    localparam int H_BACK_DEF  = 2;
    localparam int H_DISP_DEF  = 480;
    localparam int H_FRONT_DEF = 2;
    localparam int V_SYNC_DEF  = 10;
    localparam int V_BACK_DEF  = 2;
    localparam int V_DISP_DEF  = 272;
    localparam int V_FRONT_DEF = 2;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        unique case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_colorbar.sv
// lcd_colorbar: maps a requested column to one of eight vertical
// bars and registers the colour, matching the renderer's latency.
module lcd_colorbar
    import lcd_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF
)
(
    input  logic             lcd_pclk,
    input  logic             sys_rst_n,
    input  logic [CNT_W-1:0] i_xpos,
    output rgb_t             o_rgb
);

    // Tiny test panels narrower than 8 pixels still get a legal divisor
    localparam int BAR_W = ((H_DISP / 8) < 1) ? 1 : (H_DISP / 8);

    logic [CNT_W-1:0] w_idx_raw;
    logic [2:0]       w_idx;
    rgb_t             r_rgb;

    assign w_idx_raw = i_xpos / CNT_W'(BAR_W);
    assign w_idx     = (w_idx_raw > CNT_W'(7)) ? 3'd7 : w_idx_raw[2:0];

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rgb <= BLACK;
        end else begin
            r_rgb <= bar_color(w_idx);
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: panel timing master producing HS/VS/DE, pixel
// request coordinates and the DE-aligned RGB bus.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
)
(
    input  logic        lcd_pclk,
    input  logic        sys_rst_n,
    input  logic        test_mode,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if (H_TOTAL > 2047 || V_TOTAL > 2047 || H_BACK < 2 || H_FRONT < 1)
    begin : g_param_chk
        $error("lcd_timing_gen: illegal timing parameters");
    end

    localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_H_SYNC  = 11'(H_SYNC);
    localparam logic [10:0] C_H_ACT   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] C_H_END   = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] C_H_REQ   = 11'(H_SYNC + H_BACK - 2);
    localparam logic [10:0] C_H_REQE  = 11'(H_SYNC + H_BACK + H_DISP - 2);
    localparam logic [10:0] C_V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_V_SYNC  = 11'(V_SYNC);
    localparam logic [10:0] C_V_ACT   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] C_V_END   = 11'(V_SYNC + V_BACK + V_DISP);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_test_q;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic        r_fs;
    rgb_t        r_rgb;

    logic        w_h_wrap;
    logic [10:0] w_h_nxt;
    logic [10:0] w_v_nxt;
    logic        w_frame_nxt;
    logic        w_de_nxt;
    logic        w_req;
    rgb_t        w_bar_rgb;
    rgb_t        w_src;

    always_comb begin
        w_h_wrap = (r_h_cnt == C_H_LAST);
        w_h_nxt  = w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_v_nxt = (r_v_cnt == C_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
        end
        w_frame_nxt = (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
        w_de_nxt    = (w_h_nxt >= C_H_ACT) && (w_h_nxt < C_H_END) &&
                      (w_v_nxt >= C_V_ACT) && (w_v_nxt < C_V_END);
    end

    // Request runs two cycles ahead of DE to cover the renderer register
    // plus our own output register.
    assign w_req = (r_v_cnt >= C_V_ACT) && (r_v_cnt < C_V_END) &&
                   (r_h_cnt >= C_H_REQ) && (r_h_cnt < C_H_REQE);

    assign pixel_xpos = w_req ? (r_h_cnt - C_H_REQ) : 11'd0;
    assign pixel_ypos = w_req ? (r_v_cnt - C_V_ACT) : 11'd0;

    lcd_colorbar #(
        .H_DISP (H_DISP)
    ) u_colorbar (
        .lcd_pclk  (lcd_pclk),
        .sys_rst_n (sys_rst_n),
        .i_xpos    (pixel_xpos),
        .o_rgb     (w_bar_rgb)
    );

    assign w_src = r_test_q ? w_bar_rgb : pixel_data;

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_test_q <= 1'b0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_de     <= 1'b0;
            r_fs     <= 1'b0;
            r_rgb    <= BLACK;
        end else begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            r_hs    <= (w_h_nxt >= C_H_SYNC);
            r_vs    <= (w_v_nxt >= C_V_SYNC);
            r_de    <= w_de_nxt;
            r_fs    <= w_frame_nxt;
            r_rgb   <= w_de_nxt ? w_src : BLACK;
            // Mode only changes on a frame boundary so bars never tear
            if (w_frame_nxt) begin
                r_test_q <= test_mode;
            end
        end
    end

    assign lcd_hs      = r_hs;
    assign lcd_vs      = r_vs;
    assign lcd_de      = r_de;
    assign lcd_rgb     = r_rgb;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: random renderer/test-mode/reset stimulus checked
// against a frame-position reference model.
module tb_lcd_timing_gen;

    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HD = 18;
    localparam int HF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VD = 4;
    localparam int VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FT = HT * VT;

    logic        lcd_pclk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        test_mode = 1'b0;
    logic [23:0] pixel_data = '0;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        frame_start;

    lcd_timing_gen #(
        .H_SYNC  (HS),
        .H_BACK  (HB),
        .H_DISP  (HD),
        .H_FRONT (HF),
        .V_SYNC  (VS),
        .V_BACK  (VB),
        .V_DISP  (VD),
        .V_FRONT (VF)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .sys_rst_n   (sys_rst_n),
        .test_mode   (test_mode),
        .pixel_data  (pixel_data),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .frame_start (frame_start)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    logic [23:0] pix_mem [VD][HD];
    logic [23:0] bars [8];

    // Renderer: registers the image pixel for the requested coordinate
    always @(posedge lcd_pclk) begin
        if (int'(pixel_xpos) < HD && int'(pixel_ypos) < VD)
            pixel_data <= pix_mem[int'(pixel_ypos)][int'(pixel_xpos)];
        else
            pixel_data <= 24'hDEAD00;
    end

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;
    int h = 0;
    int v = 0;
    logic mtq = 1'b0;
    logic rnd_tm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d h=%0d v=%0d: got %h want %h",
                     tag, k, h, v, obs, exp);
        end
    endtask

    task automatic model_check();
        int p;
        int x;
        int y;
        int bi;
        logic hw;
        logic vw;
        logic rw;
        logic [23:0] er;
        p  = k % FT;
        h  = p % HT;
        v  = p / HT;
        if (p == 0) mtq = test_mode;
        hw = (h >= HS + HB) && (h < HS + HB + HD);
        vw = (v >= VS + VB) && (v < VS + VB + VD);
        rw = vw && (h >= HS + HB - 2) && (h < HS + HB + HD - 2);
        x  = h - (HS + HB);
        y  = v - (VS + VB);
        check("hs", 32'(lcd_hs), 32'(h >= HS));
        check("vs", 32'(lcd_vs), 32'(v >= VS));
        check("de", 32'(lcd_de), 32'(hw && vw));
        check("fs", 32'(frame_start), 32'(p == 0));
        check("xpos", 32'(pixel_xpos), rw ? 32'(h - (HS + HB - 2)) : 32'd0);
        check("ypos", 32'(pixel_ypos), rw ? 32'(y) : 32'd0);
        er = 24'h0;
        if (hw && vw) begin
            bi = x / (HD / 8);
            if (bi > 7) bi = 7;
            er = mtq ? bars[bi] : pix_mem[y][x];
        end
        if (k >= FT || !(hw && vw))
            check("rgb", 32'(lcd_rgb), 32'(er));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge lcd_pclk);
            #1;
            k++;
            model_check();
            if (rnd_tm && $urandom_range(0, 199) == 0)
                test_mode = ~test_mode;
        end
    endtask

    task automatic do_reset(input int cyc);
        sys_rst_n = 1'b0;
        mtq = 1'b0;
        repeat (cyc) @(posedge lcd_pclk);
        #1;
        check("rst_hs", 32'(lcd_hs), 32'd1);
        check("rst_de", 32'(lcd_de), 32'd0);
        @(negedge lcd_pclk);
        sys_rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        int found;
        int tgt;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
        bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
        bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        for (int yy = 0; yy < VD; yy++)
            for (int xx = 0; xx < HD; xx++)
                pix_mem[yy][xx] = 24'($urandom);

        do_reset(3);
        run(3 * FT + 37);
        test_mode = 1'b1;
        run(2 * FT);
        test_mode = 1'b0;
        run(FT);
        rnd_tm = 1'b1;
        run(3 * FT);
        rnd_tm = 1'b0;

        // Pulse reset in the middle of an active line
        tgt = HS + HB + int'($urandom_range(1, HD - 2));
        found = 0;
        for (int i = 0; i < 2 * FT && found == 0; i++) begin
            run(1);
            if (h == tgt && v >= VS + VB && v < VS + VB + VD) found = 1;
        end
        check("find_active", 32'(found), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_hs", 32'(lcd_hs), 32'd1);
        check("async_vs", 32'(lcd_vs), 32'd1);
        check("async_de", 32'(lcd_de), 32'd0);
        check("async_rgb", 32'(lcd_rgb), 32'd0);
        check("async_fs", 32'(frame_start), 32'd0);
        check("async_x", 32'(pixel_xpos), 32'd0);
        do_reset(2);
        test_mode = 1'b1;
        run(2 * FT + 11);
        rnd_tm = 1'b1;
        run(2 * FT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
